counter_hex_n: RTL and testbench

COUNTER_HEX_N -- requirements
Module: counter_hex_n

---
 rtl/counter_hex_n_pkg.sv | 17 +
 rtl/counter_hex_n_seg7.sv | 11 +
 rtl/counter_hex_n.sv | 77 +++++++
 tb/tb_counter_hex_n.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_hex_n_pkg.sv
// Shared seven-segment display constants: glyph table and output polarity.
package counter_hex_n_pkg;

   localparam int   SEG_W          = 7;
   localparam logic SEG_ACTIVE_LOW = 1'b1;

   // Lit-segment patterns {g,f,e,d,c,b,a}, 1 = segment on, for 0-9 A b C d E F
   localparam logic [SEG_W-1:0] SEG7_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] nib);
      return SEG7_GLYPH[nib] ^ {SEG_W{SEG_ACTIVE_LOW}};
   endfunction

endpackage

// File: rtl/counter_hex_n_seg7.sv
// One hex digit to seven-segment decoder, polarity taken from the package.
module hex_digit_seg7
   import counter_hex_n_pkg::*;
(
   input  logic [3:0]       nib,
   output logic [SEG_W-1:0] seg
);

   assign seg = seg7_encode(nib);

endmodule

// File: rtl/counter_hex_n.sv
// Up/down modulo-N counter with load, cascade carry, sticky wrap flag and
// per-nibble seven-segment outputs.
module counter_hex_n
   import counter_hex_n_pkg::*;
#(
   parameter  int     WIDTH   = 8,
   parameter  longint MODULUS = 256,
   localparam int     DIGITS  = WIDTH / 4
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   En,
   input  logic                   Up,
   input  logic                   Load,
   input  logic [WIDTH-1:0]       D,
   input  logic                   ClrOvf,
   output logic [WIDTH-1:0]       Q,
   output logic                   TC,
   output logic                   Ovf,
   output logic [SEG_W*DIGITS-1:0] HEX
);

   if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "counter_hex_n: WIDTH must be a multiple of 4 in 4..32");
   end
   if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
      $fatal(1, "counter_hex_n: MODULUS must be in 2..2**WIDTH");
   end

   // One extra bit so MODULUS = 2**WIDTH is representable.
   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE_W = (WIDTH+1)'(1);

   logic [WIDTH:0] q_ext, d_ext, q_nxt;
   logic           at_max, at_zero;
   logic           unused_msb;

   always_comb begin
      q_ext   = {1'b0, Q};
      d_ext   = {1'b0, D};
      at_max  = (q_ext == MAX_W);
      at_zero = (q_ext == '0);
      TC      = En & ~Load & ((Up & at_max) | (~Up & at_zero));
      if (Load)
         q_nxt = (d_ext < MOD_W) ? d_ext : MAX_W;
      else if (En)
         q_nxt = Up ? (at_max ? '0 : q_ext + ONE_W)
                    : (at_zero ? MAX_W : q_ext - ONE_W);
      else
         q_nxt = q_ext;
   end

   // Next state never exceeds MODULUS-1, so the top bit is always zero.
   assign unused_msb = q_nxt[WIDTH];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Q   <= '0;
         Ovf <= 1'b0;
      end else begin
         Q <= q_nxt[WIDTH-1:0];
         if (TC)
            Ovf <= 1'b1;
         else if (ClrOvf)
            Ovf <= 1'b0;
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      hex_digit_seg7 u_seg (
         .nib (Q[4*k+3:4*k]),
         .seg (HEX[SEG_W*k+SEG_W-1:SEG_W*k])
      );
   end

endmodule

// File: tb/tb_counter_hex_n.sv
// Self-checking bench: directed scenarios plus randomized traffic vs a model.
module tb_counter_hex_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // default instance: WIDTH=8, MODULUS=256
   logic        r8 = 1'b0, ld8 = 1'b0, en8 = 1'b0, up8 = 1'b1, clr8 = 1'b0;
   logic [7:0]  d8 = '0, q8;
   logic        tc8, ovf8;
   logic [13:0] hex8;

   // decade instance: WIDTH=4, MODULUS=10
   logic        r4 = 1'b0, ld4 = 1'b0, en4 = 1'b0, up4 = 1'b1, clr4 = 1'b0;
   logic [3:0]  d4 = '0, q4;
   logic        tc4, ovf4;
   logic [6:0]  hex4;

   // two-decade cascade
   logic        rc = 1'b0, enc = 1'b0, one = 1'b1, zero = 1'b0;
   logic [3:0]  zero4 = '0, q_c0, q_c1;
   logic        tc_c0, tc_c1, ovf_c0, ovf_c1;
   logic [6:0]  hex_c0, hex_c1;

   counter_hex_n dut (
      .Clock(clk), .Reset(r8), .En(en8), .Up(up8), .Load(ld8), .D(d8),
      .ClrOvf(clr8), .Q(q8), .TC(tc8), .Ovf(ovf8), .HEX(hex8));

   counter_hex_n #(.WIDTH(4), .MODULUS(10)) dut10 (
      .Clock(clk), .Reset(r4), .En(en4), .Up(up4), .Load(ld4), .D(d4),
      .ClrOvf(clr4), .Q(q4), .TC(tc4), .Ovf(ovf4), .HEX(hex4));

   counter_hex_n #(.WIDTH(4), .MODULUS(10)) c0 (
      .Clock(clk), .Reset(rc), .En(enc), .Up(one), .Load(zero), .D(zero4),
      .ClrOvf(zero), .Q(q_c0), .TC(tc_c0), .Ovf(ovf_c0), .HEX(hex_c0));

   counter_hex_n #(.WIDTH(4), .MODULUS(10)) c1 (
      .Clock(clk), .Reset(rc), .En(tc_c0), .Up(one), .Load(zero), .D(zero4),
      .ClrOvf(zero), .Q(q_c1), .TC(tc_c1), .Ovf(ovf_c1), .HEX(hex_c1));

   // reference model state
   int mq8 = 0, mq4 = 0;
   bit movf8 = 0, movf4 = 0;

   function automatic int mdl_next(int q, int m, bit rst, bit ld, bit en, bit up, int d);
      if (rst) return 0;
      if (ld)  return (d < m) ? d : m - 1;
      if (en)  return up ? (q + 1) % m : (q + m - 1) % m;
      return q;
   endfunction

   // a wrap is a count step that would leave the range 0..m-1
   function automatic bit mdl_wrap(int q, int m, bit ld, bit en, bit up);
      int raw;
      raw = up ? q + 1 : q - 1;
      return en && !ld && (raw < 0 || raw >= m);
   endfunction

   function automatic logic [6:0] glyph(int n);
      case (n)
         0: return 7'b1000000;  1: return 7'b1111001;
         2: return 7'b0100100;  3: return 7'b0110000;
         4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;
         8: return 7'b0000000;  9: return 7'b0010000;
         10: return 7'b0001000; 11: return 7'b0000011;
         12: return 7'b1000110; 13: return 7'b0100001;
         14: return 7'b0000110; default: return 7'b0001110;
      endcase
   endfunction

   task automatic tick();
      int n8, n4;
      bit o8, o4;
      n8 = mdl_next(mq8, 256, r8, ld8, en8, up8, int'(d8));
      o8 = r8 ? 1'b0 : mdl_wrap(mq8, 256, ld8, en8, up8) ? 1'b1 : clr8 ? 1'b0 : movf8;
      n4 = mdl_next(mq4, 10, r4, ld4, en4, up4, int'(d4));
      o4 = r4 ? 1'b0 : mdl_wrap(mq4, 10, ld4, en4, up4) ? 1'b1 : clr4 ? 1'b0 : movf4;
      @(posedge clk);
      #1;
      mq8 = n8; movf8 = o8; mq4 = n4; movf4 = o4;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         r8 = 1'b1; ld8 = 1'(i); en8 = 1'b1; clr8 = 1'(i >> 1); d8 = 8'h55;
         r4 = 1'b1; ld4 = 1'(i); en4 = 1'b1; clr4 = 1'b0; d4 = 4'h7;
         tick();
         checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL reset_q8: got %0h want 0", q8); end
         checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_ovf8: got %0b want 0", ovf8); end
         checks++; if (hex8 !== {7'b1000000, 7'b1000000}) begin errors++; $display("FAIL reset_hex8: got %0h want %0h", hex8, {7'b1000000, 7'b1000000}); end
         checks++; if (q4 !== 4'h0 || hex4 !== 7'b1000000) begin errors++; $display("FAIL reset_q4: got %0h/%0h want 0/40", q4, hex4); end
      end
      ld8 = 1'b0; en8 = 1'b1; up8 = 1'b0; #1;
      checks++; if (tc8 !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got %0b want 1", tc8); end
      up8 = 1'b1; #1;
      checks++; if (tc8 !== 1'b0) begin errors++; $display("FAIL reset_tc_up: got %0b want 0", tc8); end
      up8 = 1'b0; ld8 = 1'b1; #1;
      checks++; if (tc8 !== 1'b0) begin errors++; $display("FAIL reset_tc_load: got %0b want 0", tc8); end
      r8 = 1'b0; r4 = 1'b0; ld8 = 1'b0; en8 = 1'b0; ld4 = 1'b0; en4 = 1'b0; clr8 = 1'b0;
   endtask

   task automatic test_count_up();
      r8 = 1'b1; tick(); r8 = 1'b0;
      en8 = 1'b1; up8 = 1'b1; ld8 = 1'b0; clr8 = 1'b0;
      for (int i = 0; i < 256; i++) begin
         #1;
         checks++; if (tc8 !== (i == 255)) begin errors++; $display("FAIL up_tc i=%0d: got %0b want %0b", i, tc8, (i == 255)); end
         checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL up_ovf_early i=%0d: got %0b want 0", i, ovf8); end
         tick();
         checks++; if (q8 !== 8'((i + 1) % 256)) begin errors++; $display("FAIL up_q i=%0d: got %0h want %0h", i, q8, (i + 1) % 256); end
         if (i + 1 == 8'hA5) begin
            checks++; if (hex8 !== {7'h08, 7'h12}) begin errors++; $display("FAIL hex_a5: got %0h want %0h", hex8, {7'h08, 7'h12}); end
         end
      end
      checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL up_ovf_wrap: got %0b want 1", ovf8); end
      en8 = 1'b0;
   endtask

   task automatic test_mod10_down();
      r4 = 1'b1; tick(); r4 = 1'b0;
      en4 = 1'b1; up4 = 1'b0; ld4 = 1'b0; clr4 = 1'b0; #1;
      checks++; if (tc4 !== 1'b1) begin errors++; $display("FAIL m10_tc: got %0b want 1", tc4); end
      tick();
      checks++; if (q4 !== 4'd9) begin errors++; $display("FAIL m10_q: got %0d want 9", q4); end
      checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL m10_ovf: got %0b want 1", ovf4); end
      checks++; if (hex4 !== 7'b0010000) begin errors++; $display("FAIL m10_hex: got %0h want 10", hex4); end
      en4 = 1'b0;
   endtask

   task automatic test_load();
      r8 = 1'b1; tick(); r8 = 1'b0;
      ld8 = 1'b1; en8 = 1'b1; up8 = 1'b0; d8 = 8'h3C; tick();
      checks++; if (q8 !== 8'h3C || ovf8 !== 1'b0) begin errors++; $display("FAIL load_clean: got %0h/%0b want 3c/0", q8, ovf8); end
      d8 = 8'h00; tick();
      ld8 = 1'b0; tick();
      checks++; if (q8 !== 8'hFF || ovf8 !== 1'b1) begin errors++; $display("FAIL load_then_down: got %0h/%0b want ff/1", q8, ovf8); end
      ld8 = 1'b1; d8 = 8'h3C; tick();
      checks++; if (q8 !== 8'h3C || ovf8 !== 1'b1) begin errors++; $display("FAIL load_keep_ovf: got %0h/%0b want 3c/1", q8, ovf8); end
      ld8 = 1'b0; en8 = 1'b0;
      ld4 = 1'b1; en4 = 1'b1; up4 = 1'b1;
      d4 = 4'hF; tick();
      checks++; if (q4 !== 4'd9) begin errors++; $display("FAIL load_sat_f: got %0d want 9", q4); end
      d4 = 4'hA; tick();
      checks++; if (q4 !== 4'd9) begin errors++; $display("FAIL load_sat_a: got %0d want 9", q4); end
      d4 = 4'h5; tick();
      checks++; if (q4 !== 4'd5) begin errors++; $display("FAIL load_5: got %0d want 5", q4); end
      ld4 = 1'b0; en4 = 1'b0;
   endtask

   task automatic test_reset_priority();
      ld8 = 1'b1; d8 = 8'd77; en8 = 1'b0; tick();
      checks++; if (q8 !== 8'd77) begin errors++; $display("FAIL rp_load77: got %0d want 77", q8); end
      r8 = 1'b1; ld8 = 1'b1; en8 = 1'b1; up8 = 1'b1; d8 = 8'd3; tick();
      checks++; if (q8 !== 8'd0 || ovf8 !== 1'b0) begin errors++; $display("FAIL rp_reset: got %0d/%0b want 0/0", q8, ovf8); end
      r8 = 1'b0; ld8 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++; if (q8 !== 8'(k)) begin errors++; $display("FAIL rp_resume k=%0d: got %0d want %0d", k, q8, k); end
      end
      en8 = 1'b0;
   endtask

   task automatic test_clrovf();
      ld8 = 1'b1; d8 = 8'hFF; en8 = 1'b0; clr8 = 1'b0; tick();
      ld8 = 1'b0; en8 = 1'b1; up8 = 1'b1; clr8 = 1'b1; tick();
      checks++; if (q8 !== 8'h00 || ovf8 !== 1'b1) begin errors++; $display("FAIL clr_vs_wrap: got %0h/%0b want 0/1", q8, ovf8); end
      en8 = 1'b0; tick();
      checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL clr_after: got %0b want 0", ovf8); end
      clr8 = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         r8 = ($urandom_range(0, 15) == 0); ld8 = ($urandom_range(0, 7) == 0);
         en8 = ($urandom_range(0, 3) != 0); up8 = 1'($urandom); clr8 = ($urandom_range(0, 7) == 0);
         d8 = 8'($urandom);
         r4 = ($urandom_range(0, 15) == 0); ld4 = ($urandom_range(0, 7) == 0);
         en4 = ($urandom_range(0, 3) != 0); up4 = 1'($urandom); clr4 = ($urandom_range(0, 7) == 0);
         d4 = 4'($urandom);
         #1;
         checks++; if (tc8 !== mdl_wrap(mq8, 256, ld8, en8, up8)) begin errors++; $display("FAIL rnd_tc8 n=%0d: got %0b want %0b", n, tc8, mdl_wrap(mq8, 256, ld8, en8, up8)); end
         checks++; if (tc4 !== mdl_wrap(mq4, 10, ld4, en4, up4)) begin errors++; $display("FAIL rnd_tc4 n=%0d: got %0b want %0b", n, tc4, mdl_wrap(mq4, 10, ld4, en4, up4)); end
         tick();
         checks++; if (q8 !== 8'(mq8) || ovf8 !== movf8) begin errors++; $display("FAIL rnd_q8 n=%0d: got %0h/%0b want %0h/%0b", n, q8, ovf8, mq8, movf8); end
         checks++; if (hex8 !== {glyph(mq8 / 16), glyph(mq8 % 16)}) begin errors++; $display("FAIL rnd_hex8 n=%0d: got %0h", n, hex8); end
         checks++; if (q4 !== 4'(mq4) || ovf4 !== movf4) begin errors++; $display("FAIL rnd_q4 n=%0d: got %0h/%0b want %0h/%0b", n, q4, ovf4, mq4, movf4); end
         checks++; if (hex4 !== glyph(mq4)) begin errors++; $display("FAIL rnd_hex4 n=%0d: got %0h want %0h", n, hex4, glyph(mq4)); end
      end
      r8 = 1'b0; ld8 = 1'b0; en8 = 1'b0; clr8 = 1'b0;
      r4 = 1'b0; ld4 = 1'b0; en4 = 1'b0; clr4 = 1'b0;
   endtask

   task automatic test_cascade();
      rc = 1'b1; enc = 1'b1; tick(); rc = 1'b0;
      checks++; if (q_c1 !== 4'd0 || q_c0 !== 4'd0) begin errors++; $display("FAIL cas_reset: got %0d%0d want 00", q_c1, q_c0); end
      for (int i = 1; i <= 100; i++) begin
         tick();
         checks++;
         if (q_c1 !== 4'((i % 100) / 10) || q_c0 !== 4'(i % 10)) begin
            errors++; $display("FAIL cas_bcd i=%0d: got %0d%0d want %0d", i, q_c1, q_c0, i % 100);
         end
      end
      enc = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_count_up();
      test_mod10_down();
      test_load();
      test_reset_priority();
      test_clrovf();
      test_random();
      test_cascade();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
